// File: rtl/vector_sum_sched.sv
// vector_sum_sched: issues vectors to an external summing pipeline, tracks
// them with a valid shift register and buffers returned sums in a
// first-word-fall-through FIFO. Issue is credit-gated (in-flight plus
// buffered) so the FIFO can never overflow, and a flush drains everything
// before reporting completion.
// Optional: define VECTOR_SUM_SCHED_STATS_EN to add the stat_issued and
// stat_stall counters.
module vector_sum_sched #(
    parameter int DIM        = 2,
    parameter int W_u        = 32,
    parameter int LATENCY    = DIM,
    parameter int FIFO_DEPTH = 4,
    localparam int RES_W     = W_u + $clog2(DIM)
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*W_u-1:0]   in_vec,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [DIM*W_u-1:0]   dp_u,
    input  logic [RES_W-1:0]     dp_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_W-1:0]     out_sum,
    output logic                 busy
`ifdef VECTOR_SUM_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_stall
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             r_state;
    logic               r_flush_done;
    logic [LATENCY-1:0] r_vld;
    logic [CW-1:0]      r_in_flight;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [RES_W-1:0]   r_mem [FIFO_DEPTH];

    logic               w_xfer;
    logic               w_tap;
    logic               w_pop;
    logic [CW:0]        w_credit;

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    assign w_credit   = {1'b0, r_in_flight} + {1'b0, r_count};
    assign in_ready   = (r_state == RUN) && !flush && (w_credit < (CW+1)'(FIFO_DEPTH));
    assign w_xfer     = in_valid && in_ready;
    assign dp_u       = w_xfer ? in_vec : '0;
    assign w_tap      = r_vld[LATENCY-1];
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_sum    = r_mem[r_rd_ptr];
    assign busy       = (r_in_flight != '0) || (r_count != '0);
    assign flush_done = r_flush_done;

    // Control FSM: leave IDLE after reset, enter DRAIN on flush, return when empty.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                IDLE:    r_state <= RUN;
                RUN:     if (flush) r_state <= DRAIN;
                DRAIN: begin
                    if (r_in_flight == '0 && r_count == '0) begin
                        r_state      <= RUN;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Valid shift register and in-flight counter mirror the summing pipeline.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_vld       <= '0;
            r_in_flight <= '0;
        end else begin
            r_vld       <= (r_vld << 1) | LATENCY'(w_xfer);
            r_in_flight <= r_in_flight + CW'(w_xfer) - CW'(w_tap);
        end
    end

    // Result FIFO: push on tap, pop on output handshake; pointers wrap naturally.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_tap) begin
                r_mem[r_wr_ptr] <= dp_sum;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_tap, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef VECTOR_SUM_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;

    // Free-running wrap-around counters of accepted vectors and stalled offers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_xfer)               r_stat_issued <= r_stat_issued + 32'd1;
            if (in_valid && !in_ready) r_stat_stall  <= r_stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/vector_sum_sched.md
VECTOR_SUM_SCHED -- requirements
Module: vector_sum_sched

Interface
REQ-001 Parameters SHALL be:
  - DIM, 2, number of elements per vector.
  - W_u, 32, element width in bits.
  - LATENCY, DIM, cycles from datapath input to valid datapath sum.
  - FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
REQ-002 Ports SHALL be (name, direction, width, meaning; RES_W = W_u+CLOG2(DIM)):
  - Clock, in, 1, sole clock; all state on rising edge.
  - Resetn, in, 1, asynchronous active-low reset.
  - in_valid, in, 1, input vector offered.
  - in_ready, out, 1, scheduler accepts vector this cycle.
  - in_vec, in, DIM*W_u, input vector; element 0 in LSBs.
  - flush, in, 1, request drain.
  - flush_done, out, 1, one-cycle pulse when drain completes.
  - dp_u, out, DIM*W_u, vector driven to the summing pipeline.
  - dp_sum, in, RES_W, sum returned by the summing pipeline.
  - out_valid, out, 1, result available.
  - out_ready, in, 1, consumer takes result.
  - out_sum, out, RES_W, head-of-FIFO result.
  - busy, out, 1, any vector in flight or buffered.

Function
REQ-003 A transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-004 On an input transfer, dp_u SHALL equal in_vec combinationally that cycle; otherwise dp_u SHALL be all zeros.
REQ-005 A LATENCY-deep valid shift register SHALL shift in the transfer bit each cycle; its tap SHALL mark dp_sum valid exactly LATENCY cycles after the transfer.
REQ-006 When the tap is 1, dp_sum SHALL be written to the FIFO that cycle, in issue order.
REQ-007 in_flight SHALL count transfers not yet reaching the tap; credit = in_flight + fifo_count.
REQ-008 in_ready SHALL be 1 only in state RUN with credit < FIFO_DEPTH, so the FIFO never overflows.
REQ-009 The credit check SHALL use registered counts; a same-cycle FIFO pop SHALL NOT release credit until the next cycle.
REQ-010 The FIFO SHALL be first-word-fall-through: out_valid = (fifo_count != 0), out_sum = head entry.
REQ-011 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 The state machine SHALL have states IDLE, RUN and DRAIN.
REQ-013 IDLE SHALL go to RUN unconditionally the cycle after reset release.
REQ-014 RUN SHALL go to DRAIN when flush=1; no transfer SHALL be accepted in that cycle.
REQ-015 DRAIN SHALL hold in_ready=0 and go to RUN when in_flight==0 and fifo_count==0, pulsing flush_done for that one cycle.
REQ-016 A flush arriving while already idle SHALL complete with flush_done exactly 1 cycle after entering DRAIN.
REQ-017 busy SHALL equal (in_flight != 0) || (fifo_count != 0).
REQ-018 Results SHALL NOT be modified or truncated: out_sum equals dp_sum bit-for-bit at RES_W.

Reset
REQ-019 While Resetn=0, the block SHALL hold these values:
  - state IDLE;
  - in_ready, out_valid, flush_done and busy at 0;
  - dp_u and out_sum at 0;
  - shift register, counters and FIFO pointers cleared.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight and buffered results; no result SHALL appear after deassertion.

Configuration
REQ-021 With macro VECTOR_SUM_SCHED_STATS_EN defined, the block SHALL add these outputs:
  - stat_issued, 32 bits, accepted-vector count;
  - stat_stall, 32 bits, count of cycles with in_valid && !in_ready.
  Both SHALL wrap on overflow and be cleared by reset.
REQ-022 Without VECTOR_SUM_SCHED_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 Single vector: DIM=2, LATENCY=2, in_vec={5,3} at cycle 0, model dp_sum=8 at cycle 2. Required: out_valid=1, out_sum=8 at cycle 3.
REQ-024 Back-to-back: 4 vectors on consecutive cycles, out_ready=1. Required: four results in issue order on consecutive cycles, and in_ready stays 1 throughout.
REQ-025 Backpressure: out_ready=0 and in_valid held 1, FIFO_DEPTH=4. Required: exactly 4 transfers, then in_ready=0; one pop restores in_ready the following cycle.
REQ-026 Flush: pulse flush with 2 vectors in flight. Required: in_ready=0 until both results are popped, flush_done pulses once, then state returns to RUN.
REQ-027 Reset mid-stream: Resetn low with 3 results buffered. Required: out_valid=0 and busy=0 immediately, and no stale result after release.
REQ-028 Stats (with VECTOR_SUM_SCHED_STATS_EN): run REQ-025's scenario for 10 cycles. Required: stat_issued=4 and stat_stall=6.
